// File: rtl/mem_master_if.sv
// Bundle of command, write-data, read-data and memory-pin signals used by mem_master.
// The master modport is the engine's view; slave is the host/memory side.
interface mem_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, mem_data_out,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy,
    output mem_read, mem_write, mem_addr, mem_data_in
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, mem_data_out,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy,
    input  mem_read, mem_write, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_master.sv
// Burst read/write initiator for a single-port memory with registered data_out.
// One read outstanding at a time; all memory pins and read-response outputs are registered.
module mem_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP} state_t;

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W:0]    CNT_ONE  = 1;
  localparam logic [LAT_W-1:0]  LAT_ONE  = 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W:0]    cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    lat_d         = lat_q;
    cmd_ready_d   = cmd_ready_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    rd_valid_d    = rd_valid_q;
    rd_data_d     = rd_data_q;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = bus.cmd_addr;
          cnt_d       = {1'b0, bus.cmd_len} + CNT_ONE;
          if (bus.cmd_write) begin
            state_d = WR;
          end else begin
            state_d    = RD_ISSUE;
            mem_read_d = 1'b1;
            mem_addr_d = bus.cmd_addr;
          end
        end
      end

      WR: begin
        if (bus.wr_valid) begin
          mem_write_d   = 1'b1;
          mem_addr_d    = addr_q;
          mem_data_in_d = bus.wr_data;
          addr_d        = addr_q + ADDR_ONE;
          cnt_d         = cnt_q - CNT_ONE;
          // Last beat still sits on the bus next cycle, so a new command may overlap it.
          if (cnt_q == CNT_ONE) begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
          end
        end
      end

      RD_ISSUE: begin
        state_d = RD_WAIT;
        lat_d   = '0;
      end

      RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          rd_data_d  = bus.mem_data_out;
          rd_valid_d = 1'b1;
          state_d    = RD_RESP;
        end else begin
          lat_d = lat_q + LAT_ONE;
        end
      end

      RD_RESP: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          if (cnt_q != CNT_ONE) begin
            cnt_d      = cnt_q - CNT_ONE;
            addr_d     = addr_q + ADDR_ONE;
            mem_read_d = 1'b1;
            mem_addr_d = addr_q + ADDR_ONE;
            state_d    = RD_ISSUE;
          end else begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      lat_q         <= '0;
      cmd_ready_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      cmd_ready_q   <= cmd_ready_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.wr_ready    = (state_q == WR);
  assign bus.busy        = (state_q != IDLE);
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: memory model, shadow-memory reference, directed cases plus random bursts.
module tb_mem_master;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 5;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus();

  mem_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory with one-edge registered read port
  logic [7:0] mem_m [32] = '{default: 8'h00};
  logic [7:0] mem_dout = 8'h00;
  always @(posedge clk) begin
    if (bus.mem_write) mem_m[bus.mem_addr] <= bus.mem_data_in;
    if (bus.mem_read)  mem_dout <= mem_m[bus.mem_addr];
  end
  assign bus.mem_data_out = mem_dout;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] ref_mem [32] = '{default: 8'h00};
  wr_t        wq[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every memory write pulse must match the next accepted beat in order
  always @(negedge clk) begin
    if (rst) begin
      check_eq("rw_excl", 32'(bus.mem_read & bus.mem_write), 0);
      if (bus.mem_write) begin
        if (wq.size() == 0) begin
          check_eq("wr_unexpected", 32'(bus.mem_write), 0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check_eq("wr_addr", 32'(bus.mem_addr), 32'(e.a));
          check_eq("wr_data", 32'(bus.mem_data_in), 32'(e.d));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctl"}, 32'({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy,
                                 bus.mem_read, bus.mem_write}), 0);
    check_eq({tag, "_mem"}, 32'({bus.mem_addr, bus.mem_data_in}), 0);
    check_eq({tag, "_rd"}, 32'(bus.rd_data), 0);
  endtask

  task automatic send_cmd(input bit wr, input logic [4:0] a, input logic [4:0] l);
    int t;
    t = 0;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("cmd_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_eq("cmd_busy", 32'({bus.busy, bus.cmd_ready}), 32'h2);
  endtask

  task automatic write_beats(input logic [4:0] a, input int nb, input logic [63:0] pat,
                             input bit rnd, input logic [7:0] d0);
    int k;
    int cyc;
    logic v;
    logic [7:0] d;
    logic [4:0] wa;
    k = 0;
    cyc = 0;
    while (k < nb && cyc < 400) begin
      check_eq("wr_ready", 32'(bus.wr_ready), 1);
      v  = rnd ? 1'($urandom_range(0, 1)) : ((cyc < 64) ? pat[cyc] : 1'b1);
      d  = rnd ? 8'($urandom) : d0 + 8'(k);
      wa = a + 5'(k);
      bus.wr_valid = v;
      bus.wr_data  = d;
      if (v) begin
        wq.push_back('{a: wa, d: d});
        ref_mem[wa] = d;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.wr_valid = 1'b0;
    check_eq("wr_done", 32'({bus.busy, bus.cmd_ready}), 32'h1);
  endtask

  task automatic read_burst(input logic [4:0] a, input logic [4:0] l,
                            input int stall_beat, input int stall_n);
    logic [4:0] ra;
    logic [7:0] e;
    int w;
    send_cmd(1'b0, a, l);
    for (int k = 0; k <= int'(l); k++) begin
      ra = a + 5'(k);
      check_eq("rd_issue", 32'(bus.mem_read), 1);
      check_eq("rd_addr", 32'(bus.mem_addr), 32'(ra));
      @(negedge clk);
      check_eq("rd_pulse", 32'(bus.mem_read), 0);
      check_eq("wr_ready_rd", 32'(bus.wr_ready), 0);
      w = 1;
      // Noise that must be ignored while a read is in flight
      while (!bus.rd_valid && w < 20) begin
        bus.rd_ready  = 1'($urandom_range(0, 1));
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_write = 1'b1;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 8'($urandom);
        @(negedge clk);
        w++;
      end
      bus.rd_ready  = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.wr_valid  = 1'b0;
      check_eq("rd_lat", w, 2);
      e = ref_mem[ra];
      check_eq("rd_data", 32'(bus.rd_data), 32'(e));
      if (k == stall_beat) begin
        repeat (stall_n) begin
          @(negedge clk);
          check_eq("rd_hold", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b1, e}));
          check_eq("rd_noissue", 32'(bus.mem_read), 0);
        end
      end
      bus.rd_ready = 1'b1;
      @(negedge clk);
      bus.rd_ready = 1'b0;
      check_eq("rd_drop", 32'(bus.rd_valid), 0);
    end
    check_eq("rd_done", 32'({bus.busy, bus.cmd_ready}), 32'h1);
  endtask

  initial begin
    logic [4:0] ra;
    logic [4:0] rl;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    // Reset hold and release
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_quiet("rst_hold");
    end
    rst = 1'b1;
    check_eq("rel_rdy0", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    check_eq("rel_rdy1", 32'({bus.busy, bus.cmd_ready}), 32'h1);

    // Single write then single read
    send_cmd(1'b1, 5'd5, 5'd0);
    write_beats(5'd5, 1, '1, 1'b0, 8'hA5);
    read_burst(5'd5, 5'd0, -1, 0);

    // Wrapping burst
    send_cmd(1'b1, 5'd30, 5'd3);
    write_beats(5'd30, 4, '1, 1'b0, 8'h01);
    read_burst(5'd30, 5'd3, -1, 0);

    // Back-pressure on beat 0 of a two-beat read
    read_burst(5'd30, 5'd1, 0, 5);

    // Gapped write: valid pattern 1,0,0,1,1
    send_cmd(1'b1, 5'd12, 5'd2);
    write_beats(5'd12, 3, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 8'h50);

    // Reset in the middle of an 8-beat write
    send_cmd(1'b1, 5'd10, 5'd7);
    bus.wr_valid = 1'b1; bus.wr_data = 8'h3C;
    wq.push_back('{a: 5'd10, d: 8'h3C}); ref_mem[10] = 8'h3C;
    @(negedge clk);
    bus.wr_data = 8'hC3;
    wq.push_back('{a: 5'd11, d: 8'hC3}); ref_mem[11] = 8'hC3;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    bus.wr_valid = 1'b1; bus.wr_data = 8'h99;
    wq.push_back('{a: 5'd12, d: 8'h99});
    @(negedge clk);
    bus.wr_valid = 1'b0;
    check_eq("pre_rst_wr", 32'(bus.mem_write), 1);
    #2 rst = 1'b0;
    #1 check_quiet("mid_rst");
    wq.delete();
    @(negedge clk);
    rst = 1'b1;
    check_eq("rel2_rdy0", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    check_eq("rel2_rdy1", 32'(bus.cmd_ready), 1);
    read_burst(5'd10, 5'd2, -1, 0);
    send_cmd(1'b1, 5'd20, 5'd1);
    write_beats(5'd20, 2, '1, 1'b1, 8'h00);
    read_burst(5'd20, 5'd1, -1, 0);

    // Maximum-length bursts
    send_cmd(1'b1, 5'd7, 5'd31);
    write_beats(5'd7, 32, '1, 1'b1, 8'h00);
    read_burst(5'd7, 5'd31, 3, 2);

    // Random mix
    for (int i = 0; i < 30; i++) begin
      ra = 5'($urandom);
      rl = 5'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) begin
        send_cmd(1'b1, ra, rl);
        write_beats(ra, int'(rl) + 1, '1, 1'b1, 8'h00);
      end else begin
        read_burst(ra, rl, int'($urandom_range(0, int'(rl))), int'($urandom_range(0, 3)));
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Initiator-side engine for the single-port memory bus.
- Accepts single or burst read/write commands over a valid/ready command channel.
- Streams write data in and read data out, each through its own valid/ready channel.
- Drives the memory's read/write/addr/data_in pins and captures its registered data_out.
- Sits between test/traffic generators or a host and the memory model.

Parameters:
ADDR_W, 5, memory address width (32 locations)
DATA_W, 8, data width
LEN_W, 5, burst length field width; beats = cmd_len+1
RD_LAT, 1, clock edges from the memory sampling mem_read to mem_data_out being valid

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous and active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  start address
cmd_len  in  LEN_W  beats minus one
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat accept
wr_data  in  DATA_W  write beat data
rd_valid  out  1  read beat valid
rd_ready  in  1  read beat accept
rd_data  out  DATA_W  read beat data
busy  out  1  command in progress (state != IDLE)
mem_read  out  1  to memory read
mem_write  out  1  to memory write
mem_addr  out  ADDR_W  to memory addr
mem_data_in  out  DATA_W  to memory data_in
mem_data_out  in  DATA_W  from memory data_out

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0, including cmd_ready.
- First rising edge after release sets cmd_ready=1.
- Reset mid-burst aborts immediately: mem_read/mem_write drop at once, remaining beats are discarded, no response is produced.
- All mem_* outputs and rd_valid/rd_data are registered.
- mem_read and mem_write are never 1 together.
- States: IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch addr, beat count (cmd_len+1) and direction; cmd_ready=0 from that edge.
  - Write command -> WR.
  - Read command -> RD_ISSUE, with mem_read=1 and mem_addr=cmd_addr registered at the handshake edge.
- WR:
  - wr_ready=1.
  - At each edge with wr_valid=1, register mem_write=1, mem_addr=cur_addr, mem_data_in=wr_data; cur_addr++, count--.
  - At an edge with wr_valid=0, register mem_write=0; no address or count change.
  - After the last beat is accepted: go IDLE and set cmd_ready=1. mem_write falls one edge later, because the last beat is still driven for one cycle.
  - A following command may be accepted while that last write is on the bus; ordering is preserved by the registered outputs.
- RD_ISSUE:
  - mem_read=1 for exactly one cycle.
  - Next edge: mem_read=0, go RD_WAIT.
- RD_WAIT:
  - Wait RD_LAT edges, then capture mem_data_out into rd_data, set rd_valid=1, go RD_RESP.
  - With RD_LAT=1, rd_valid rises 2 edges after the cmd (or previous rd) handshake edge.
- RD_RESP:
  - rd_valid and rd_data are held stable until rd_ready=1.
  - At the handshake edge rd_valid=0.
  - If beats remain: cur_addr++, register mem_read=1 with the new addr, go RD_ISSUE.
  - Otherwise go IDLE with cmd_ready=1.
  - Only one read is outstanding at any time.
- Address arithmetic is modulo 2^ADDR_W: 31 wraps to 0. Maximum burst is 2^LEN_W = 32 beats.
- wr_valid outside WR is ignored (wr_ready=0).
- rd_ready with rd_valid=0 has no effect.
- cmd_valid while busy is not accepted.

Test Plan:
1. Hold rst=0 for 3 cycles, then release -> all outputs 0 while in reset; cmd_ready=1 after the first edge, busy=0.
2. Write addr 5 with data 0xA5, len 0; then read addr 5 -> one mem_write pulse at addr 5; rd_data=0xA5 with rd_valid high 2 edges after the read cmd handshake; mem_read high exactly 1 cycle.
3. Write burst addr 30, len 3, data 0x01..0x04, then read burst addr 30, len 3 -> writes land at 30,31,0,1; read returns 0x01,0x02,0x03,0x04 in order.
4. Read burst len 1 with rd_ready held low for 5 cycles on beat 0 -> rd_valid/rd_data stable throughout, no mem_read issued; beat 1 issued at the edge rd_ready rises.
5. Write burst len 2 with wr_valid pattern 1,0,0,1,1 -> mem_write pattern 1,0,0,1,1 at addrs n,–,–,n+1,n+2; busy drops after the 3rd beat.
6. rst=0 asynchronously mid-cycle after 2 beats of a len 7 write -> mem_write=0 immediately; after release, a read of those addrs returns the 2 written values, and a fresh command completes normally.
